// File: rtl/exception_sequencer.sv
// Fixed-priority exception sequencer: raise -> ack -> handler -> return
// handshake with the datapath exception unit, one exception in flight.
module exception_sequencer #(
  parameter int NSRC        = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exc_req,
  input  logic [NSRC-1:0] exc_mask,
  input  logic            eret_req,
  input  logic            ExcAck,
  input  logic            err_clr,
  output logic            Exc,
  output logic            ERet,
  output logic [3:0]      EStatus,
  output logic [NSRC-1:0] pending,
  output logic            busy,
  output logic [1:0]      err
);

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAISE,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t          r_state, w_state_n;
  logic [NSRC-1:0] r_pend, w_pend_n;
  logic [NSRC-1:0] w_elig, w_clr;
  logic [3:0]      r_sel, w_sel_n, w_pick;
  logic [3:0]      r_est, w_est_n;
  logic [TW-1:0]   r_timer, w_timer_n;
  logic            r_exc, w_exc_n;
  logic            r_eret, w_eret_n;
  logic            r_busy, w_busy_n;
  logic [1:0]      r_err, w_err_n, w_eset;
  logic            w_any, w_tmo;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_elig = r_pend & ~exc_mask;
    w_any  = |w_elig;
    w_pick = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_pick = 4'(i);
    end
  end

  assign w_tmo = (r_timer == TLAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_sel   <= '0;
      r_est   <= '0;
      r_timer <= '0;
      r_exc   <= 1'b0;
      r_eret  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_sel   <= w_sel_n;
      r_est   <= w_est_n;
      r_timer <= w_timer_n;
      r_exc   <= w_exc_n;
      r_eret  <= w_eret_n;
      r_busy  <= w_busy_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:    if (w_any) w_state_n = S_RAISE;
      S_RAISE: begin
        if (ExcAck)     w_state_n = S_HANDLER;
        else if (w_tmo) w_state_n = S_IDLE;
      end
      S_HANDLER: if (eret_req) w_state_n = S_RETURN;
      S_RETURN:  w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_exc_n   = r_exc;
    w_eret_n  = 1'b0;
    w_est_n   = r_est;
    w_sel_n   = r_sel;
    w_timer_n = r_timer;
    w_clr     = '0;
    w_eset    = '0;
    unique case (r_state)
      S_IDLE: begin
        w_exc_n = 1'b0;
        w_est_n = '0;
        if (w_any) begin
          w_sel_n   = w_pick;
          w_est_n   = w_pick + 4'd1;
          w_exc_n   = 1'b1;
          w_timer_n = '0;
        end
      end
      S_RAISE: begin
        if (ExcAck) begin
          w_exc_n = 1'b0;
          w_clr   = NSRC'(1) << r_sel;
        end else if (w_tmo) begin
          w_exc_n   = 1'b0;
          w_est_n   = '0;
          w_eset[0] = 1'b1;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end
      S_HANDLER: begin
        w_exc_n = 1'b0;
        if (eret_req) w_eret_n = 1'b1;
      end
      S_RETURN: begin
        w_est_n = '0;
      end
      default: begin
        w_exc_n = 1'b0;
        w_est_n = '0;
      end
    endcase
    if (eret_req && r_state != S_HANDLER) w_eset[1] = 1'b1;
  end

  // Set beats clear on both the pending bits and the sticky errors.
  assign w_pend_n = (r_pend & ~w_clr) | exc_req;
  assign w_err_n  = (err_clr ? 2'b00 : r_err) | w_eset;
  assign w_busy_n = (w_state_n != S_IDLE);

  assign Exc     = r_exc;
  assign ERet    = r_eret;
  assign EStatus = r_est;
  assign pending = r_pend;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule
